// File: rtl/dwc_upconv_wchan_packer_pkg.sv
// Shared definitions for the UpConv W-channel packer: width derivation,
// close-condition encoding and the wrap-base pointer helper.
package dwc_upconv_wchan_packer_pkg;

  function automatic int out_bytes(input int width);
    return width / 8;
  endfunction

  function automatic int offs_width(input int width);
    return $clog2(width / 8);
  endfunction

  // Reasons a wide beat closes on the current narrow beat.
  typedef struct packed {
    logic last;
    logic fixed;
    logic ovf;
    logic wrap;
  } close_t;

  function automatic logic close_any(input close_t c);
    return c.last | c.fixed | c.ovf | c.wrap;
  endfunction

  // Lane where a wrapping burst restarts: the start address rounded down to the
  // total burst span, reduced to a lane offset of the wide bus.
  function automatic logic [5:0] wrap_base(input logic [5:0] addr,
                                           input logic [7:0] wlen,
                                           input logic [2:0] size,
                                           input logic [5:0] lane_mask);
    logic [15:0] span;
    logic [15:0] span_m1;
    span    = ({8'd0, wlen} + 16'd1) << size;
    span_m1 = span - 16'd1;
    return addr & ~span_m1[5:0] & lane_mask;
  endfunction

endpackage

// File: rtl/dwc_upconv_wchan_packer_lane_steer.sv
// Combinational steering of one narrow beat onto the byte lanes of the wide bus
// starting at lane i_ptr and spanning i_size_shifted bytes.
module dwc_upconv_lane_steer
  import dwc_upconv_wchan_packer_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 64
) (
  input  logic [DATA_WIDTH_IN-1:0]                    i_data,
  input  logic [DATA_WIDTH_IN/8-1:0]                  i_strb,
  input  logic [offs_width(DATA_WIDTH_OUT)-1:0]       i_ptr,
  input  logic [5:0]                                  i_size_shifted,
  output logic [DATA_WIDTH_OUT-1:0]                   o_data,
  output logic [DATA_WIDTH_OUT/8-1:0]                 o_strb,
  output logic [DATA_WIDTH_OUT/8-1:0]                 o_lane_en
);
  localparam int IN_BYTES  = DATA_WIDTH_IN / 8;
  localparam int OUT_BYTES = out_bytes(DATA_WIDTH_OUT);

  logic [6:0] w_start;
  logic [6:0] w_end;

  assign w_start = 7'(i_ptr);
  assign w_end   = w_start + 7'(i_size_shifted);

  // Narrow data is address-aligned, so wide lane L always draws from narrow lane L mod IN_BYTES.
  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_lane
    localparam int         SRC  = gi % IN_BYTES;
    localparam logic [6:0] LANE = 7'(gi);
    assign o_lane_en[gi]       = (LANE >= w_start) && (LANE < w_end);
    assign o_data[gi*8 +: 8]   = i_data[SRC*8 +: 8];
    assign o_strb[gi]          = i_strb[SRC] & o_lane_en[gi];
  end

endmodule

// File: rtl/dwc_upconv_wchan_packer.sv
// Packs narrow slave-side write beats of one registered command into wide
// master-side beats and requests the next command after the last narrow beat.
module dwc_upconv_wchan_packer
  import dwc_upconv_wchan_packer_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 64,
  parameter int USER_WIDTH     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold_reg_empty,
  output logic                        hold_get_next_data,
  input  logic [5:0]                  addr,
  input  logic [2:0]                  size,
  input  logic [5:0]                  size_shifted,
  input  logic [5:0]                  mask_addr,
  input  logic [7:0]                  wlen_mst,
  input  logic [4:0]                  to_boundary,
  input  logic                        wrap_flag,
  input  logic                        fixed_flag,
  input  logic [DATA_WIDTH_IN-1:0]    s_wdata,
  input  logic [DATA_WIDTH_IN/8-1:0]  s_wstrb,
  input  logic [USER_WIDTH-1:0]       s_wuser,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [DATA_WIDTH_OUT-1:0]   m_wdata,
  output logic [DATA_WIDTH_OUT/8-1:0] m_wstrb,
  output logic [USER_WIDTH-1:0]       m_wuser,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        m_wready
);
  localparam int OUT_BYTES = out_bytes(DATA_WIDTH_OUT);
  localparam int OFFS_W    = offs_width(DATA_WIDTH_OUT);

  logic                      r_busy;
  logic [OFFS_W-1:0]         r_ptr;
  logic [7:0]                r_beat_cnt;
  logic [DATA_WIDTH_OUT-1:0] r_acc_data;
  logic [OUT_BYTES-1:0]      r_acc_strb;
  logic [DATA_WIDTH_OUT-1:0] r_m_wdata;
  logic [OUT_BYTES-1:0]      r_m_wstrb;
  logic [USER_WIDTH-1:0]     r_m_wuser;
  logic                      r_m_wlast;
  logic                      r_m_wvalid;

  logic                      w_accept;
  close_t                    w_close;
  logic                      w_close_any;
  logic [6:0]                w_ptr_sum;
  logic [5:0]                w_wrap_ptr;
  logic [OFFS_W-1:0]         w_ptr_next;
  logic [DATA_WIDTH_OUT-1:0] w_st_data;
  logic [OUT_BYTES-1:0]      w_st_strb;
  logic [OUT_BYTES-1:0]      w_lane_en;
  logic [DATA_WIDTH_OUT-1:0] w_byte_mask;
  logic [DATA_WIDTH_OUT-1:0] w_merge_data;
  logic [OUT_BYTES-1:0]      w_merge_strb;
  logic [5:0]                w_ptr_load;

  dwc_upconv_lane_steer #(
    .DATA_WIDTH_IN  (DATA_WIDTH_IN),
    .DATA_WIDTH_OUT (DATA_WIDTH_OUT)
  ) u_steer (
    .i_data         (s_wdata),
    .i_strb         (s_wstrb),
    .i_ptr          (r_ptr),
    .i_size_shifted (size_shifted),
    .o_data         (w_st_data),
    .o_strb         (w_st_strb),
    .o_lane_en      (w_lane_en)
  );

  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_mask
    assign w_byte_mask[gi*8 +: 8] = {8{w_lane_en[gi]}};
  end

  assign s_wready           = r_busy & (~r_m_wvalid | m_wready);
  assign w_accept           = s_wvalid & s_wready;
  assign hold_get_next_data = w_accept & w_close.last;

  assign w_ptr_sum     = 7'(r_ptr) + 7'(size_shifted);
  assign w_close.last  = (r_beat_cnt == wlen_mst);
  assign w_close.fixed = fixed_flag;
  assign w_close.ovf   = (w_ptr_sum >= 7'(OUT_BYTES));
  assign w_close.wrap  = wrap_flag & (r_beat_cnt == {3'd0, to_boundary});
  assign w_close_any   = close_any(w_close);

  assign w_wrap_ptr = wrap_base(addr, wlen_mst, size, 6'(OUT_BYTES - 1));
  assign w_ptr_next = fixed_flag   ? r_ptr :
                      w_close.wrap ? w_wrap_ptr[OFFS_W-1:0] :
                                     w_ptr_sum[OFFS_W-1:0];
  assign w_ptr_load = addr & mask_addr;

  // The closing beat is merged combinationally so the wide beat leaves one cycle later.
  assign w_merge_data = (w_st_data & w_byte_mask) | (r_acc_data & ~w_byte_mask);
  assign w_merge_strb = w_st_strb | (r_acc_strb & ~w_lane_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_acc_data <= '0;
      r_acc_strb <= '0;
      r_m_wdata  <= '0;
      r_m_wstrb  <= '0;
      r_m_wuser  <= '0;
      r_m_wlast  <= 1'b0;
      r_m_wvalid <= 1'b0;
    end else begin
      if (r_m_wvalid && m_wready) begin
        r_m_wvalid <= 1'b0;
      end
      if (!r_busy && !hold_reg_empty) begin
        r_ptr      <= w_ptr_load[OFFS_W-1:0];
        r_beat_cnt <= '0;
        r_busy     <= 1'b1;
      end
      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (w_close_any) begin
          r_m_wvalid <= 1'b1;
          r_m_wdata  <= w_merge_data;
          r_m_wstrb  <= w_merge_strb;
          r_m_wuser  <= s_wuser;
          r_m_wlast  <= w_close.last;
          r_acc_strb <= '0;
        end else begin
          r_acc_data <= w_merge_data;
          r_acc_strb <= w_merge_strb;
        end
        if (w_close.last) begin
          r_busy <= 1'b0;
        end else begin
          r_ptr <= w_ptr_next;
        end
      end
    end
  end

  assign m_wdata  = r_m_wdata;
  assign m_wstrb  = r_m_wstrb;
  assign m_wuser  = r_m_wuser;
  assign m_wlast  = r_m_wlast;
  assign m_wvalid = r_m_wvalid;

endmodule

// File: tb/tb_dwc_upconv_wchan_packer.sv
// Bench for the W-channel packer: command table with a byte-address model feeding
// a scoreboard, plus stall and mid-burst reset sequences.
module tb_dwc_upconv_wchan_packer;
  localparam int DWI = 32;
  localparam int DWO = 64;
  localparam int UW  = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           hold_reg_empty;
  logic           hold_get_next_data;
  logic [5:0]     addr;
  logic [2:0]     size;
  logic [5:0]     size_shifted;
  logic [5:0]     mask_addr;
  logic [7:0]     wlen_mst;
  logic [4:0]     to_boundary;
  logic           wrap_flag;
  logic           fixed_flag;
  logic [DWI-1:0] s_wdata;
  logic [3:0]     s_wstrb;
  logic [UW-1:0]  s_wuser;
  logic           s_wvalid;
  logic           s_wready;
  logic [DWO-1:0] m_wdata;
  logic [7:0]     m_wstrb;
  logic [UW-1:0]  m_wuser;
  logic           m_wlast;
  logic           m_wvalid;
  logic           m_wready;

  always #5 clk = ~clk;

  dwc_upconv_wchan_packer #(
    .DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(DWO), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst), .hold_reg_empty(hold_reg_empty),
    .hold_get_next_data(hold_get_next_data), .addr(addr), .size(size),
    .size_shifted(size_shifted), .mask_addr(mask_addr), .wlen_mst(wlen_mst),
    .to_boundary(to_boundary), .wrap_flag(wrap_flag), .fixed_flag(fixed_flag),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wuser(s_wuser), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wuser(m_wuser),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        user;
    logic        last;
  } wbeat_t;

  typedef struct {
    logic [5:0] addr;
    logic [2:0] size;
    logic [7:0] wlen;
    logic [4:0] tob;
    logic       wrap;
    logic       fixed;
    int         n_wide;
    logic [7:0] strb0;
    logic [7:0] strb_last;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  wbeat_t      exp_q[$];
  logic [7:0]  obs_strb[$];
  logic        tb_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_strb;
  logic        prev_user;
  logic        prev_last;
  int          stall_cycles = 0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{s[k]}};
    return m;
  endfunction

  // Output monitor: scoreboard pops, stall stability, next-command pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (s_wvalid && s_wready) chk("hold_get_next_data", 64'(hold_get_next_data), 64'(tb_last));
      else                      chk("hold_get_next_data idle", 64'(hold_get_next_data), 64'd0);
      if (m_wvalid && m_wready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected wide beat", 64'(m_wstrb), 64'd0);
        end else begin
          wbeat_t e;
          e = exp_q.pop_front();
          $display("wide beat: data=%h strb=%h user=%0d last=%0d", m_wdata, m_wstrb, m_wuser, m_wlast);
          chk("m_wstrb", 64'(m_wstrb), 64'(e.strb));
          chk("m_wdata", m_wdata & lane_mask(e.strb), e.data & lane_mask(e.strb));
          chk("m_wuser", 64'(m_wuser), 64'(e.user));
          chk("m_wlast", 64'(m_wlast), 64'(e.last));
          obs_strb.push_back(m_wstrb);
        end
      end
      if (m_wvalid && !m_wready) begin
        chk("s_wready in stall", 64'(s_wready), 64'd0);
        if (prev_stall) begin
          chk("stall m_wdata", m_wdata, prev_data);
          chk("stall m_wstrb", 64'(m_wstrb), 64'(prev_strb));
          chk("stall m_wuser/last", {62'd0, m_wuser, m_wlast}, {62'd0, prev_user, prev_last});
        end
        prev_stall = 1'b1;
        prev_data  = m_wdata;
        prev_strb  = m_wstrb;
        prev_user  = m_wuser[0];
        prev_last  = m_wlast;
        stall_cycles++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] st, input logic u,
                           input logic last, input logic close);
    logic rdy;
    logic accepted;
    accepted = 1'b0;
    s_wvalid = 1'b1;
    s_wdata  = d;
    s_wstrb  = st;
    s_wuser  = u;
    tb_last  = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rdy = s_wready;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    s_wvalid = 1'b0;
    tb_last  = 1'b0;
    chk("s_wready handshake", 64'(accepted), 64'd1);
    if (close) chk("wide beat latency", 64'(m_wvalid), 64'd1);
  endtask

  task automatic load_cmd(input vec_t v);
    logic [5:0] ss;
    ss = 6'd1 << v.size;
    @(posedge clk);
    #1;
    addr           = v.addr;
    size           = v.size;
    size_shifted   = ss;
    mask_addr      = 6'h07 & ~(ss - 6'd1);
    wlen_mst       = v.wlen;
    to_boundary    = v.tob;
    wrap_flag      = v.wrap;
    fixed_flag     = v.fixed;
    hold_reg_empty = 1'b0;
  endtask

  // Model works on full byte addresses; lane = address mod 8.
  task automatic run_cmd(input vec_t v);
    int          sz, cur, wl, wb, a, lane, base, nw;
    logic [31:0] nd[256];
    logic [3:0]  ns[256];
    logic        nu[256];
    logic        nc[256];
    wbeat_t      acc;
    sz  = 1 << v.size;
    cur = int'(v.addr) & ~(sz - 1);
    wl  = (int'(v.wlen) + 1) * sz;
    wb  = (cur / wl) * wl;
    acc.data = '0;
    acc.strb = '0;
    for (int i = 0; i <= int'(v.wlen); i++) begin
      if (v.fixed)     a = cur;
      else if (v.wrap) a = wb + ((cur - wb + i * sz) % wl);
      else             a = cur + i * sz;
      lane  = a % 8;
      nd[i] = $urandom;
      nu[i] = 1'($urandom_range(0, 1));
      ns[i] = '0;
      for (int k = 0; k < sz; k++) begin
        ns[i][(a + k) % 4]               = 1'b1;
        acc.data[(lane + k) * 8 +: 8]    = nd[i][((a + k) % 4) * 8 +: 8];
        acc.strb[lane + k]               = 1'b1;
      end
      nc[i] = (i == int'(v.wlen)) || v.fixed || (lane + sz >= 8) || (v.wrap && i == int'(v.tob));
      if (nc[i]) begin
        acc.user = nu[i];
        acc.last = (i == int'(v.wlen));
        exp_q.push_back(acc);
        acc.data = '0;
        acc.strb = '0;
      end
    end
    base = obs_strb.size();
    load_cmd(v);
    for (int i = 0; i <= int'(v.wlen); i++)
      send_beat(nd[i], ns[i], nu[i], i == int'(v.wlen), nc[i]);
    hold_reg_empty = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    nw = obs_strb.size() - base;
    chk("wide beat count", 64'(nw), 64'(v.n_wide));
    if (nw > 0) begin
      chk("first wide strb", 64'(obs_strb[base]), 64'(v.strb0));
      chk("last wide strb", 64'(obs_strb[obs_strb.size() - 1]), 64'(v.strb_last));
    end
  endtask

  initial begin
    vec_t rv;
    //              addr   sz    wlen  tob   wrap  fixed n  strb0  strbL
    vecs[0] = '{6'h00, 3'd2, 8'd3, 5'd0, 1'b0, 1'b0, 2, 8'hFF, 8'hFF};
    vecs[1] = '{6'h03, 3'd0, 8'd2, 5'd0, 1'b0, 1'b0, 1, 8'h38, 8'h38};
    vecs[2] = '{6'h04, 3'd2, 8'd2, 5'd0, 1'b0, 1'b1, 3, 8'hF0, 8'hF0};
    vecs[3] = '{6'h08, 3'd2, 8'd3, 5'd1, 1'b1, 1'b0, 2, 8'hFF, 8'hFF};
    vecs[4] = '{6'h02, 3'd1, 8'd4, 5'd0, 1'b0, 1'b0, 2, 8'hFC, 8'h0F};
    vecs[5] = '{6'h05, 3'd0, 8'd3, 5'd2, 1'b1, 1'b0, 2, 8'hE0, 8'h10};
    vecs[6] = '{6'h04, 3'd2, 8'd0, 5'd0, 1'b0, 1'b0, 1, 8'hF0, 8'hF0};

    rst = 1'b1; hold_reg_empty = 1'b1; m_wready = 1'b1;
    addr = '0; size = '0; size_shifted = 6'd1; mask_addr = '0; wlen_mst = '0;
    to_boundary = '0; wrap_flag = 1'b0; fixed_flag = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wuser = '0; s_wvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_wvalid", 64'(m_wvalid), 64'd0);
    chk("reset m_wlast", 64'(m_wlast), 64'd0);
    chk("reset m_wdata", m_wdata, 64'd0);
    chk("reset m_wstrb/user", {55'd0, m_wstrb, m_wuser}, 64'd0);
    chk("reset s_wready/hgnd", {62'd0, s_wready, hold_get_next_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("s_wready with empty hold reg", 64'(s_wready), 64'd0);
    end
    @(posedge clk); #1;
    s_wvalid = 1'b0;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Back-pressure: hold m_wready low five cycles once the first wide beat appears.
    @(posedge clk); #1;
    m_wready = 1'b0;
    stall_cycles = 0;
    fork
      run_cmd(vecs[0]);
      begin
        for (int c = 0; c < 100 && !m_wvalid; c++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        m_wready = 1'b1;
      end
    join
    chk("stall cycles observed", 64'(stall_cycles >= 5), 64'd1);

    // Reset after one of four beats, then a fresh command from a new address.
    rv = '{6'h00, 3'd2, 8'd3, 5'd0, 1'b0, 1'b0, 0, 8'h00, 8'h00};
    load_cmd(rv);
    send_beat(32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    hold_reg_empty = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("hgnd during reset", 64'(hold_get_next_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset m_wvalid", 64'(m_wvalid), 64'd0);
    chk("post-reset m_wstrb", 64'(m_wstrb), 64'd0);
    chk("post-reset s_wready", 64'(s_wready), 64'd0);
    rv = '{6'h04, 3'd2, 8'd1, 5'd0, 1'b0, 1'b0, 2, 8'hF0, 8'h0F};
    run_cmd(rv);

    repeat (3) @(posedge clk);
    chk("final scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
